master_cmd_sequencer: RTL and testbench

// Consumer of the per-master command set (read/write strobe, slave, address, data, burst count)

---
 rtl/master_cmd_sequencer.sv | 139 +++++++++++++
 tb/tb_master_cmd_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/master_cmd_sequencer.sv
// Per-master command sequencer: turns a read/write request edge into a burst of
// single-beat valid/ready issues on one serial-bus master port, one beat outstanding.
module master_cmd_sequencer #(
    parameter int SLAVE_LEN = 2,
    parameter int SLAVE_NUM = 3,
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read,
    input  logic                 write,
    input  logic [SLAVE_LEN-1:0] slave,
    input  logic [ADDR_LEN:0]    address,
    input  logic [DATA_LEN-1:0]  data,
    input  logic [BURST_LEN:0]   burst_num,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic                 cmd_rw,
    output logic [SLAVE_LEN-1:0] cmd_slave,
    output logic [ADDR_LEN:0]    cmd_addr,
    output logic [DATA_LEN-1:0]  cmd_wdata,
    input  logic                 resp_valid,
    input  logic [DATA_LEN-1:0]  resp_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [DATA_LEN-1:0]  last_rdata,
    output logic [BURST_LEN:0]   beats_done
);

    localparam int TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SLAVE_LEN:0] SLAVE_MAX = (SLAVE_LEN + 1)'(SLAVE_NUM);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, FINISH} state_t;

    state_t               state;
    state_t               state_next;
    logic                 read_prev;
    logic                 write_prev;
    logic                 read_edge;
    logic                 write_edge;
    logic                 request;
    logic                 slave_ok;
    logic                 last_beat;
    logic                 timer_expired;
    logic [BURST_LEN:0]   beats;
    logic [TIMER_W-1:0]   timer;

    assign read_edge     = read & ~read_prev;
    assign write_edge    = write & ~write_prev;
    assign request       = read_edge | write_edge;
    assign slave_ok      = (slave != '0) && ({1'b0, slave} <= SLAVE_MAX);
    assign last_beat     = (beats_done + (BURST_LEN + 1)'(1)) == beats;
    assign timer_expired = timer == TIMER_W'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (request && slave_ok) state_next = ISSUE;
            ISSUE:     if (cmd_ready) state_next = WAIT_RESP;
            WAIT_RESP: begin
                if (resp_valid) begin
                    state_next = last_beat ? FINISH : ISSUE;
                end else if (timer_expired) begin
                    state_next = IDLE;
                end
            end
            FINISH:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = (state == ISSUE);
        busy      = (state == ISSUE) || (state == WAIT_RESP);
        done      = (state == FINISH);
    end

    // Edge registers track continuously so a level held across a burst never re-triggers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_prev  <= 1'b0;
            write_prev <= 1'b0;
            cmd_rw     <= 1'b0;
            cmd_slave  <= '0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            beats      <= '0;
            beats_done <= '0;
            last_rdata <= '0;
            timer      <= '0;
            error      <= 1'b0;
        end else begin
            read_prev  <= read;
            write_prev <= write;
            error      <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        cmd_rw     <= read_edge;
                        cmd_slave  <= slave;
                        cmd_addr   <= address;
                        cmd_wdata  <= data;
                        beats      <= (burst_num == '0) ? (BURST_LEN + 1)'(1) : burst_num;
                        beats_done <= '0;
                        if (!slave_ok) error <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) timer <= '0;
                end
                WAIT_RESP: begin
                    if (resp_valid) begin
                        beats_done <= beats_done + (BURST_LEN + 1)'(1);
                        if (cmd_rw) last_rdata <= resp_rdata;
                        if (!last_beat) cmd_addr <= cmd_addr + (ADDR_LEN + 1)'(1);
                    end else if (timer_expired) begin
                        error <= 1'b1;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_master_cmd_sequencer.sv
// Scoreboard bench for master_cmd_sequencer: expected beats queued at request time,
// popped and compared as the DUT issues them on the bus.
module tb_master_cmd_sequencer;

    localparam int TIMEOUT = 1023;

    typedef struct packed {
        logic        rw;
        logic [1:0]  slave;
        logic [12:0] addr;
        logic [7:0]  wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  slave = '0;
    logic [12:0] address = '0;
    logic [7:0]  data = '0;
    logic [12:0] burst_num = '0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        cmd_rw;
    logic [1:0]  cmd_slave;
    logic [12:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        resp_valid = 1'b0;
    logic [7:0]  resp_rdata = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  last_rdata;
    logic [12:0] beats_done;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];
    logic [7:0] rdata_q[$];

    master_cmd_sequencer #(
        .SLAVE_LEN(2), .SLAVE_NUM(3), .ADDR_LEN(12), .DATA_LEN(8),
        .BURST_LEN(12), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .read(read), .write(write), .slave(slave),
        .address(address), .data(data), .burst_num(burst_num),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_slave(cmd_slave), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
        .done(done), .error(error), .last_rdata(last_rdata), .beats_done(beats_done)
    );

    always #5 clk = ~clk;

    task automatic push_burst(input logic rw, input logic [1:0] s, input logic [12:0] a,
                              input logic [7:0] d, input int n);
        logic [12:0] addr_i;
        exp_t e;
        addr_i = a;
        for (int i = 0; i < n; i++) begin
            e.rw = rw; e.slave = s; e.addr = addr_i; e.wdata = d;
            exp_q.push_back(e);
            addr_i = addr_i + 13'd1;
        end
    endtask

    task automatic set_cmd(input logic [1:0] s, input logic [12:0] a, input logic [7:0] d,
                           input logic [12:0] b);
        slave = s; address = a; data = d; burst_num = b;
    endtask

    task automatic idle(input int n);
        read = 1'b0; write = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Bus-side responder and scoreboard consumer.
    task automatic serve_burst(input int ready_delay, input int resp_delay, input int poke_cyc,
                               input int abort_beat, input int max_cycles,
                               output int n_done, output int n_err, output int first_valid,
                               output int wait_cycles, output bit aborted);
        int vcount, rcount, popped;
        bit waiting, finished;
        logic [13:0] held;
        exp_t e;
        n_done = 0; n_err = 0; first_valid = -1; wait_cycles = 0; aborted = 0;
        vcount = 0; rcount = 0; popped = 0; waiting = 0; finished = 0; held = '0;
        for (int cyc = 0; cyc < max_cycles && !finished; cyc++) begin
            @(negedge clk);
            cmd_ready = 1'b0;
            resp_valid = 1'b0;
            if (cyc == poke_cyc) read = 1'b1;
            if (done === 1'b1) n_done++;
            if (error === 1'b1) n_err++;
            if (cmd_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            checks++;
            if ((done & error) !== 1'b0) begin
                failures++;
                $display("FAIL done_error_exclusive: done=%b error=%b required not both", done, error);
            end
            if (done === 1'b1 || error === 1'b1) begin
                finished = 1;
                wait_cycles = rcount;
            end else if (waiting) begin
                checks++;
                if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL wait_resp_outputs: cmd_valid=%b busy=%b required 0/1", cmd_valid, busy);
                end
                if (popped == abort_beat && rcount == 1) begin
                    reset = 1'b1;
                    aborted = 1;
                    finished = 1;
                end else if (resp_delay >= 0 && rcount == resp_delay) begin
                    resp_valid = 1'b1;
                    resp_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : 8'h00;
                    waiting = 0;
                end else begin
                    rcount++;
                end
            end else if (cmd_valid === 1'b1) begin
                if (vcount == 0) begin
                    held = {cmd_rw, cmd_addr};
                end else begin
                    checks++;
                    if ({cmd_rw, cmd_addr} !== held) begin
                        failures++;
                        $display("FAIL issue_stable: rw/addr=%h required %h", {cmd_rw, cmd_addr}, held);
                    end
                end
                if (vcount >= ready_delay) begin
                    cmd_ready = 1'b1;
                    popped++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_issue: addr=%h required no issue", cmd_addr);
                    end else begin
                        e = exp_q.pop_front();
                        if ({cmd_rw, cmd_slave, cmd_addr, cmd_wdata} !== e) begin
                            failures++;
                            $display("FAIL issue_beat: rw=%b slave=%0d addr=%h wdata=%h required rw=%b slave=%0d addr=%h wdata=%h",
                                     cmd_rw, cmd_slave, cmd_addr, cmd_wdata, e.rw, e.slave, e.addr, e.wdata);
                        end
                    end
                    waiting = 1; rcount = 0; vcount = 0;
                end else begin
                    vcount++;
                end
            end
        end
        if (!finished) begin
            checks++; failures++;
            $display("FAIL serve_bound: no done/error within %0d cycles", max_cycles);
        end
        cmd_ready = 1'b0;
        resp_valid = 1'b0;
    endtask

    task automatic check_burst_end(input string name, input int n_done, input int n_err,
                                   input logic [12:0] exp_beats);
        checks++;
        if (n_done != 1 || n_err != 0 || beats_done !== exp_beats || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_end: done=%0d err=%0d beats_done=%0d left=%0d required 1/0/%0d/0",
                     name, n_done, n_err, beats_done, exp_q.size(), exp_beats);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_valid, cmd_rw, cmd_slave, cmd_addr, cmd_wdata, busy, done, error, last_rdata, beats_done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b busy=%b addr=%h beats=%0d required all zero",
                     cmd_valid, busy, cmd_addr, beats_done);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_valid, busy, done, error} !== 4'b0) begin
            failures++;
            $display("FAIL reset_release: valid=%b busy=%b done=%b error=%b required 0", cmd_valid, busy, done, error);
        end
    endtask

    task automatic test_write_burst;
        int nd, ne, fv, wc; bit ab;
        set_cmd(2'd2, 13'h010, 8'hA5, 13'd3);
        push_burst(1'b0, 2'd2, 13'h010, 8'hA5, 3);
        write = 1'b1;
        serve_burst(0, 2, -1, -1, 200, nd, ne, fv, wc, ab);
        checks++;
        if (fv != 0) begin
            failures++;
            $display("FAIL write_latency: first cmd_valid cycle=%0d required 0", fv);
        end
        check_burst_end("write", nd, ne, 13'd3);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width: done=%b busy=%b required 0/0", done, busy);
        end
        idle(2);
    endtask

    task automatic test_read_wrap;
        int nd, ne, fv, wc; bit ab;
        set_cmd(2'd1, 13'h1FFF, 8'h3C, 13'd2);
        push_burst(1'b1, 2'd1, 13'h1FFF, 8'h3C, 2);
        rdata_q.push_back(8'h11);
        rdata_q.push_back(8'h22);
        read = 1'b1;
        serve_burst(1, 0, -1, -1, 200, nd, ne, fv, wc, ab);
        check_burst_end("read_wrap", nd, ne, 13'd2);
        checks++;
        if (last_rdata !== 8'h22) begin
            failures++;
            $display("FAIL read_last_rdata: last_rdata=%h required 22", last_rdata);
        end
        idle(3);
    endtask

    task automatic test_burst_zero;
        int nd, ne, fv, wc; bit ab;
        set_cmd(2'd3, 13'h07FF, 8'h5A, 13'd0);
        push_burst(1'b0, 2'd3, 13'h07FF, 8'h5A, 1);
        write = 1'b1;
        serve_burst(0, 1, -1, -1, 200, nd, ne, fv, wc, ab);
        check_burst_end("burst_zero", nd, ne, 13'd1);
        checks++;
        if (last_rdata !== 8'h22) begin
            failures++;
            $display("FAIL write_keeps_rdata: last_rdata=%h required 22", last_rdata);
        end
        idle(3);
    endtask

    task automatic test_illegal_slave;
        int nd, ne, fv, wc; bit ab;
        set_cmd(2'd0, 13'h0123, 8'hEE, 13'd4);
        write = 1'b1;
        serve_burst(0, 0, -1, -1, 20, nd, ne, fv, wc, ab);
        checks++;
        if (ne != 1 || nd != 0 || fv != -1 || busy !== 1'b0 || beats_done !== 13'd0) begin
            failures++;
            $display("FAIL illegal_slave: err=%0d done=%0d first_valid=%0d busy=%b beats=%0d required 1/0/-1/0/0",
                     ne, nd, fv, busy, beats_done);
        end
        @(negedge clk);
        checks++;
        if (error !== 1'b0 || cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL illegal_error_pulse: error=%b cmd_valid=%b required 0/0", error, cmd_valid);
        end
        idle(2);
    endtask

    task automatic test_stall_timeout;
        int nd, ne, fv, wc; bit ab;
        set_cmd(2'd1, 13'h00AA, 8'h77, 13'd4);
        push_burst(1'b0, 2'd1, 13'h00AA, 8'h77, 1);
        write = 1'b1;
        serve_burst(5, -1, -1, -1, TIMEOUT + 100, nd, ne, fv, wc, ab);
        checks++;
        if (ne != 1 || nd != 0 || busy !== 1'b0 || beats_done !== 13'd0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL timeout_abort: err=%0d done=%0d busy=%b beats=%0d left=%0d required 1/0/0/0/0",
                     ne, nd, busy, beats_done, exp_q.size());
        end
        checks++;
        if (wc < TIMEOUT || wc > TIMEOUT + 1) begin
            failures++;
            $display("FAIL timeout_length: waited=%0d required %0d..%0d", wc, TIMEOUT, TIMEOUT + 1);
        end
        idle(3);
    endtask

    task automatic test_back_to_back;
        int nd, ne, fv, wc, extra; bit ab;
        set_cmd(2'd2, 13'h0300, 8'h0F, 13'd2);
        push_burst(1'b1, 2'd2, 13'h0300, 8'h0F, 2);
        rdata_q.push_back(8'h81);
        rdata_q.push_back(8'h82);
        read = 1'b1; write = 1'b1;
        serve_burst(0, 1, -1, -1, 200, nd, ne, fv, wc, ab);
        check_burst_end("both_edges", nd, ne, 13'd2);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (cmd_valid !== 1'b0 || busy !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0 || last_rdata !== 8'h82) begin
            failures++;
            $display("FAIL held_level_no_rerun: active_cycles=%0d last_rdata=%h required 0/82", extra, last_rdata);
        end
        idle(2);
        set_cmd(2'd2, 13'h0040, 8'h99, 13'd2);
        push_burst(1'b0, 2'd2, 13'h0040, 8'h99, 2);
        write = 1'b1;
        serve_burst(0, 3, 2, -1, 200, nd, ne, fv, wc, ab);
        check_burst_end("edge_while_busy", nd, ne, 13'd2);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (cmd_valid !== 1'b0 || busy !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL busy_edge_ignored: active_cycles=%0d required 0", extra);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_burst;
        int nd, ne, fv, wc; bit ab;
        set_cmd(2'd3, 13'h0100, 8'h42, 13'd3);
        push_burst(1'b0, 2'd3, 13'h0100, 8'h42, 3);
        write = 1'b1;
        serve_burst(0, 2, -1, 2, 200, nd, ne, fv, wc, ab);
        write = 1'b0;
        #1;
        checks++;
        if (!ab || {cmd_valid, cmd_rw, cmd_slave, cmd_addr, cmd_wdata, busy, done, error, last_rdata, beats_done} !== '0) begin
            failures++;
            $display("FAIL mid_burst_reset: aborted=%0d busy=%b addr=%h wdata=%h beats=%0d last=%h required all zero",
                     ab, busy, cmd_addr, cmd_wdata, beats_done, last_rdata);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_cmd(2'd1, 13'h0020, 8'h13, 13'd1);
        push_burst(1'b0, 2'd1, 13'h0020, 8'h13, 1);
        write = 1'b1;
        serve_burst(0, 0, -1, -1, 200, nd, ne, fv, wc, ab);
        checks++;
        if (fv != 0) begin
            failures++;
            $display("FAIL fresh_latency: first cmd_valid cycle=%0d required 0", fv);
        end
        check_burst_end("fresh_after_reset", nd, ne, 13'd1);
        idle(2);
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_wrap();
        test_burst_zero();
        test_illegal_slave();
        test_stall_timeout();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
